// File: rtl/mod_clkgen_pkg.sv
// Shared types and power-on configuration for the multi-channel clock generator.
package mod_clkgen_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    PEND    = 2'd2
  } state_t;

  localparam int DEF_PHASE = 0;
  localparam int DEF_DEAD  = 1;

  // Default high time leaves room for two one-cycle dead gaps in the period.
  function automatic int def_duty(input int period);
    return period / 2 - 1;
  endfunction

endpackage

// File: rtl/mod_clkgen_multi_if.sv
// Configuration handshake bundle: one offer carries a complete period/phase/duty/dead set.
interface mod_clkgen_multi_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 8
);
  logic                    CFG_VALID;
  logic                    CFG_READY;
  logic [CNT_W-1:0]        CFG_PERIOD;
  logic [NUM_CH*CNT_W-1:0] CFG_PHASE;
  logic [NUM_CH*CNT_W-1:0] CFG_DUTY;
  logic [CNT_W-1:0]        CFG_DEAD;
  logic                    CFG_ERR;

  modport master (
    output CFG_VALID, CFG_PERIOD, CFG_PHASE, CFG_DUTY, CFG_DEAD,
    input  CFG_READY, CFG_ERR
  );

  modport slave (
    input  CFG_VALID, CFG_PERIOD, CFG_PHASE, CFG_DUTY, CFG_DEAD,
    output CFG_READY, CFG_ERR
  );
endinterface

// File: rtl/mod_clkgen_ch.sv
// One modulation channel: phase-shifted position within the period, compared against duty and dead time.
module mod_clkgen_ch #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             run,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] phase,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] dead,
  output logic             mod,
  output logic             modn
);

  logic [CNT_W:0] pos;
  logic           mod_next;
  logic           modn_next;

  // One extra bit so cnt+period never wraps for arbitrary (non power-of-two) periods.
  always_comb begin
    if (cnt >= phase) begin
      pos = {1'b0, cnt} - {1'b0, phase};
    end else begin
      pos = {1'b0, cnt} + {1'b0, period} - {1'b0, phase};
    end
    mod_next  = (pos < {1'b0, duty});
    modn_next = (pos >= ({1'b0, duty} + {1'b0, dead})) &&
                ((pos + {1'b0, dead}) < {1'b0, period});
  end

  always_ff @(posedge clk) begin
    if (srst || !run) begin
      mod  <= 1'b0;
      modn <= 1'b0;
    end else begin
      mod  <= mod_next;
      modn <= modn_next;
    end
  end

endmodule

// File: rtl/mod_clkgen_multi.sv
// Multi-channel non-overlapping clock generator with glitch-free reconfiguration at period wrap.
module mod_clkgen_multi
  import mod_clkgen_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int CNT_W      = 8,
  parameter int RST_PERIOD = 100
) (
  input  logic               CLK_IN,
  input  logic               RESET,
  input  logic               ENABLE,
  mod_clkgen_multi_if.slave  cfg,
  output logic [NUM_CH-1:0]  CLK_OUT_MOD,
  output logic [NUM_CH-1:0]  CLK_OUT_MODN,
  output logic               CLK_OUT_SYNC
);

  localparam logic [CNT_W-1:0] DEF_PERIOD_V = CNT_W'(RST_PERIOD);
  localparam logic [CNT_W-1:0] DEF_DUTY_V   = CNT_W'(def_duty(RST_PERIOD));
  localparam logic [CNT_W-1:0] DEF_DEAD_V   = CNT_W'(DEF_DEAD);
  localparam logic [CNT_W-1:0] DEF_PHASE_V  = CNT_W'(DEF_PHASE);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [CNT_W-1:0]        act_period_reg, act_dead_reg;
  logic [NUM_CH*CNT_W-1:0] act_phase_reg, act_duty_reg;
  logic [CNT_W-1:0]        stg_period_reg, stg_dead_reg;
  logic [NUM_CH*CNT_W-1:0] stg_phase_reg, stg_duty_reg;
  logic                    sync_reg;
  logic                    err_reg;

  logic [NUM_CH-1:0]       ch_bad;
  logic                    cfg_ok;
  logic                    cfg_acc;
  logic                    cfg_rej;
  logic                    running;
  logic                    wrap;
  logic                    load_active;
  logic                    load_staged;
  logic                    commit;

  // 2*DEAD is formed by a shift into a wider word so large dead times cannot alias.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chk
    assign ch_bad[gi] =
      (cfg.CFG_PHASE[gi*CNT_W +: CNT_W] >= cfg.CFG_PERIOD) ||
      (({2'b00, cfg.CFG_DUTY[gi*CNT_W +: CNT_W]} + {1'b0, cfg.CFG_DEAD, 1'b0}) >
       {2'b00, cfg.CFG_PERIOD});
  end

  assign cfg_ok        = (cfg.CFG_PERIOD >= CNT_W'(2)) && !(|ch_bad);
  assign cfg.CFG_READY = (state_reg != PEND);
  assign cfg_acc       = cfg.CFG_VALID && cfg.CFG_READY && cfg_ok;
  assign cfg_rej       = cfg.CFG_VALID && cfg.CFG_READY && !cfg_ok;
  assign cfg.CFG_ERR   = err_reg;
  assign running       = (state_reg != STOPPED);
  assign wrap          = (cnt_reg == act_period_reg - CNT_W'(1));
  assign CLK_OUT_SYNC  = sync_reg;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    load_active = 1'b0;
    load_staged = 1'b0;
    commit      = 1'b0;
    case (state_reg)
      STOPPED: begin
        cnt_next    = '0;
        load_active = cfg_acc;
        if (ENABLE) state_next = RUN;
      end
      RUN: begin
        cnt_next = wrap ? '0 : cnt_reg + CNT_W'(1);
        if (cfg_acc) begin
          load_staged = 1'b1;
          state_next  = PEND;
        end else if (wrap && !ENABLE) begin
          state_next = STOPPED;
        end
      end
      PEND: begin
        cnt_next = wrap ? '0 : cnt_reg + CNT_W'(1);
        if (wrap) begin
          commit     = 1'b1;
          state_next = ENABLE ? RUN : STOPPED;
        end
      end
      default: begin
        state_next = STOPPED;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      state_reg      <= STOPPED;
      cnt_reg        <= '0;
      sync_reg       <= 1'b0;
      err_reg        <= 1'b0;
      act_period_reg <= DEF_PERIOD_V;
      act_dead_reg   <= DEF_DEAD_V;
      act_phase_reg  <= {NUM_CH{DEF_PHASE_V}};
      act_duty_reg   <= {NUM_CH{DEF_DUTY_V}};
      stg_period_reg <= '0;
      stg_dead_reg   <= '0;
      stg_phase_reg  <= '0;
      stg_duty_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sync_reg  <= running && (cnt_reg == '0);
      err_reg   <= cfg_rej;
      // The active set only moves while stopped or on the wrap edge, so no runt pulses.
      if (load_active) begin
        act_period_reg <= cfg.CFG_PERIOD;
        act_dead_reg   <= cfg.CFG_DEAD;
        act_phase_reg  <= cfg.CFG_PHASE;
        act_duty_reg   <= cfg.CFG_DUTY;
      end else if (commit) begin
        act_period_reg <= stg_period_reg;
        act_dead_reg   <= stg_dead_reg;
        act_phase_reg  <= stg_phase_reg;
        act_duty_reg   <= stg_duty_reg;
      end
      if (load_staged) begin
        stg_period_reg <= cfg.CFG_PERIOD;
        stg_dead_reg   <= cfg.CFG_DEAD;
        stg_phase_reg  <= cfg.CFG_PHASE;
        stg_duty_reg   <= cfg.CFG_DUTY;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    mod_clkgen_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk    (CLK_IN),
      .srst   (RESET),
      .run    (running),
      .cnt    (cnt_reg),
      .period (act_period_reg),
      .phase  (act_phase_reg[gi*CNT_W +: CNT_W]),
      .duty   (act_duty_reg[gi*CNT_W +: CNT_W]),
      .dead   (act_dead_reg),
      .mod    (CLK_OUT_MOD[gi]),
      .modn   (CLK_OUT_MODN[gi])
    );
  end

endmodule

// File: tb/tb_mod_clkgen_multi.sv
// Self-checking bench: per-cycle comparison against a behavioural model plus directed corner sequences.
module tb_mod_clkgen_multi;

  localparam int NUM_CH     = 3;
  localparam int CNT_W      = 8;
  localparam int RST_PERIOD = 100;
  localparam int HMASK      = 16383;

  typedef struct {
    int period;
    int phase[NUM_CH];
    int duty[NUM_CH];
    int dead;
  } cfg_t;

  typedef struct {
    int period;
    int phase[NUM_CH];
    int duty;
    int dead;
    bit exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic [NUM_CH-1:0] mod, modn;
  logic sync;

  always #5 clk = ~clk;

  mod_clkgen_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) ifc ();

  mod_clkgen_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .RST_PERIOD(RST_PERIOD)
  ) dut (
    .CLK_IN(clk), .RESET(rst), .ENABLE(en), .cfg(ifc.slave),
    .CLK_OUT_MOD(mod), .CLK_OUT_MODN(modn), .CLK_OUT_SYNC(sync)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  logic [2*NUM_CH:0] hist [0:HMASK];

  cfg_t drv, m_act, m_stg;
  bit   drv_valid = 1'b0;
  bit   m_run = 1'b0, m_pend = 1'b0;
  int   m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
    else passes++;
  endtask

  function automatic cfg_t mk_cfg(input int period, input int p0, input int p1, input int p2,
                                  input int d0, input int d1, input int d2, input int dead);
    cfg_t c;
    c.period = period; c.dead = dead;
    c.phase[0] = p0; c.phase[1] = p1; c.phase[2] = p2;
    c.duty[0] = d0; c.duty[1] = d1; c.duty[2] = d2;
    return c;
  endfunction

  function automatic cfg_t def_cfg();
    return mk_cfg(RST_PERIOD, 0, 0, 0, RST_PERIOD/2-1, RST_PERIOD/2-1, RST_PERIOD/2-1, 1);
  endfunction

  function automatic bit legal(input cfg_t c);
    bit ok;
    ok = (c.period >= 2);
    for (int i = 0; i < NUM_CH; i++)
      if (c.phase[i] >= c.period || c.duty[i] + 2*c.dead > c.period) ok = 1'b0;
    return ok;
  endfunction

  // Expected {sync, modn, mod} from the current count using modular position arithmetic.
  function automatic logic [2*NUM_CH:0] model_out();
    logic [2*NUM_CH:0] r;
    r = '0;
    if (m_run) begin
      r[2*NUM_CH] = (m_cnt == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        int p;
        p = (m_cnt + m_act.period - m_act.phase[i]) % m_act.period;
        r[i]        = (p < m_act.duty[i]);
        r[NUM_CH+i] = (p >= m_act.duty[i] + m_act.dead) && (p < m_act.period - m_act.dead);
      end
    end
    return r;
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    if ($urandom_range(0, 1) == 0) begin
      c.period = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 255)) : int'($urandom_range(2, 40));
      c.dead = $urandom_range(0, c.period/2);
      for (int i = 0; i < NUM_CH; i++) begin
        c.duty[i]  = $urandom_range(0, c.period - 2*c.dead);
        c.phase[i] = $urandom_range(0, c.period - 1);
      end
    end else begin
      c.period = $urandom_range(0, 40);
      c.dead = $urandom_range(0, 25);
      for (int i = 0; i < NUM_CH; i++) begin
        c.duty[i]  = $urandom_range(0, 45);
        c.phase[i] = $urandom_range(0, 45);
      end
    end
    return c;
  endfunction

  task automatic drive_cfg(input cfg_t c, input bit v);
    drv = c;
    drv_valid = v;
    ifc.CFG_VALID  = v;
    ifc.CFG_PERIOD = CNT_W'(c.period);
    ifc.CFG_DEAD   = CNT_W'(c.dead);
    for (int i = 0; i < NUM_CH; i++) begin
      ifc.CFG_PHASE[i*CNT_W +: CNT_W] = CNT_W'(c.phase[i]);
      ifc.CFG_DUTY[i*CNT_W +: CNT_W]  = CNT_W'(c.duty[i]);
    end
  endtask

  // One clock: advance the model with the inputs the DUT is about to sample, then compare.
  task automatic tick();
    logic [2*NUM_CH:0] e_out;
    bit e_err, ok, acc, wrap;
    ok = legal(drv);
    e_out = '0;
    e_err = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_pend = 1'b0; m_cnt = 0; m_act = def_cfg();
    end else begin
      e_out = model_out();
      e_err = drv_valid && !m_pend && !ok;
      acc   = drv_valid && !m_pend && ok;
      wrap  = m_run && (m_cnt == m_act.period - 1);
      if (!m_run) begin
        if (acc) m_act = drv;
        m_cnt = 0;
        if (en) m_run = 1'b1;
      end else begin
        m_cnt = wrap ? 0 : m_cnt + 1;
        if (m_pend) begin
          if (wrap) begin
            m_act = m_stg; m_pend = 1'b0;
            if (!en) m_run = 1'b0;
          end
        end else if (acc) begin
          m_stg = drv; m_pend = 1'b1;
        end else if (wrap && !en) begin
          m_run = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    hist[cyc & HMASK] = {sync, modn, mod};
    chk("outputs", {25'd0, sync, modn, mod}, {25'd0, e_out});
    chk("cfg_err", {31'd0, ifc.CFG_ERR}, {31'd0, e_err});
    chk("cfg_ready", {31'd0, ifc.CFG_READY}, {31'd0, !m_pend});
    chk("overlap", {29'd0, mod & modn}, 32'd0);
  endtask

  task automatic wait_cnt(input int target);
    int n;
    n = 0;
    while (!(m_run && m_cnt == target) && n < 400) begin
      tick();
      n++;
    end
    chk("wait_cnt_reached", {31'd0, n < 400}, 32'd1);
  endtask

  function automatic int find_sync(input int from, input int upto);
    for (int i = from; i <= upto; i++)
      if (hist[i & HMASK][2*NUM_CH]) return i;
    return -1;
  endfunction

  function automatic logic hb(input int idx, input int b);
    return hist[idx & HMASK][b];
  endfunction

  initial begin
    vec_t vecs[13];
    cfg_t c10, c20;
    int s, s2, a, b, start, n0, nn, nr, v0, v1;

    c20 = mk_cfg(20, 0, 0, 0, 9, 9, 9, 1);
    c10 = mk_cfg(10, 0, 3, 7, 4, 4, 4, 1);
    drive_cfg(def_cfg(), 1'b0);

    // Reset state
    tick(); tick();
    chk("rst_ready", {31'd0, ifc.CFG_READY}, 32'd1);
    chk("rst_outputs", {24'd0, sync, modn, mod, ifc.CFG_ERR}, 32'd0);
    rst = 1'b0;

    // Default waveform after reset
    en = 1'b1;
    tick();
    start = cyc;
    repeat (250) tick();
    s = find_sync(start + 1, start + 250);
    chk("first_sync_latency", s, start + 1);
    s2 = find_sync(s + 1, start + 250);
    chk("default_sync_period", s2 - s, 100);
    n0 = 0; nn = 0;
    for (int i = 0; i < 100; i++) begin
      n0 += int'(hb(s + i, 0));
      nn += int'(hb(s + i, NUM_CH));
    end
    chk("default_mod_high", n0, 49);
    chk("default_modn_high", nn, 49);
    chk("default_gap_mid", {30'd0, hb(s + 49, 0), hb(s + 49, NUM_CH)}, 32'd0);
    chk("default_gap_end", {30'd0, hb(s + 99, 0), hb(s + 99, NUM_CH)}, 32'd0);
    $display("seq default: sync at %0d and %0d, mod=%0d modn=%0d", s, s2, n0, nn);

    // Mid-period reconfiguration to PERIOD=20
    wait_cnt(30);
    drive_cfg(c20, 1'b1);
    tick();
    drive_cfg(c20, 1'b0);
    a = cyc;
    chk("pend_ready_low", {31'd0, ifc.CFG_READY}, 32'd0);
    nr = 0;
    repeat (68) begin
      tick();
      nr += int'(ifc.CFG_READY);
    end
    chk("ready_low_until_wrap", nr, 0);
    tick();
    chk("ready_after_wrap", {31'd0, ifc.CFG_READY}, 32'd1);
    repeat (30) tick();
    s = find_sync(a + 1, a + 99);
    chk("old_period_completes", s, a + 70);
    s2 = find_sync(s + 1, a + 99);
    chk("new_period_20", s2 - s, 20);
    $display("seq reconfig20: accepted at %0d, syncs at %0d and %0d", a, s, s2);

    // PERIOD=10 with staggered phases
    drive_cfg(c10, 1'b1);
    tick();
    drive_cfg(c10, 1'b0);
    b = cyc;
    repeat (40) tick();
    s = find_sync(b + 22, b + 31);
    chk("p10_sync_found", {31'd0, s >= 0}, 32'd1);
    chk("ch0_rise", {30'd0, hb(s - 1, 0), hb(s, 0)}, 32'd1);
    chk("ch1_rise_3", {30'd0, hb(s + 2, 1), hb(s + 3, 1)}, 32'd1);
    chk("ch2_rise_7", {30'd0, hb(s + 6, 2), hb(s + 7, 2)}, 32'd1);
    chk("ch0_modn_p4_9", {30'd0, hb(s + 4, NUM_CH), hb(s + 9, NUM_CH)}, 32'd0);
    chk("ch0_modn_p5_8", {28'd0, hb(s + 5, NUM_CH), hb(s + 6, NUM_CH), hb(s + 7, NUM_CH), hb(s + 8, NUM_CH)}, 32'hF);
    $display("seq period10: sync at %0d", s);

    // Rejected offer: phase beyond period
    drive_cfg(mk_cfg(10, 12, 3, 7, 4, 4, 4, 1), 1'b1);
    tick();
    chk("err_pulse", {31'd0, ifc.CFG_ERR}, 32'd1);
    chk("err_ready_stays", {31'd0, ifc.CFG_READY}, 32'd1);
    drive_cfg(c10, 1'b0);
    tick();
    chk("err_one_cycle", {31'd0, ifc.CFG_ERR}, 32'd0);
    repeat (30) tick();
    s = find_sync(cyc - 29, cyc - 20);
    chk("err_waveform_kept", {31'd0, hb(s + 10, 2*NUM_CH)}, 32'd1);
    $display("seq reject: sync at %0d", s);

    // Zero duty and zero dead time
    drive_cfg(mk_cfg(12, 0, 5, 11, 0, 6, 3, 0), 1'b1);
    tick();
    drive_cfg(drv, 1'b0);
    repeat (30) tick();
    v0 = 0; v1 = 0;
    repeat (24) begin
      tick();
      if (mod[0] !== 1'b0) v0++;
      if (mod[1] === modn[1] || mod[2] === modn[2]) v1++;
    end
    chk("duty0_mod_low", v0, 0);
    chk("dead0_complement", v1, 0);
    $display("seq duty0/dead0: violations %0d %0d", v0, v1);

    // ENABLE drop at CNT=40
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; tick();
    wait_cnt(40);
    en = 1'b0;
    repeat (59) tick();
    chk("stop_still_running", {31'd0, modn[0]}, 32'd1);
    repeat (6) tick();
    chk("stopped_outputs", {25'd0, sync, modn, mod}, 32'd0);
    chk("stopped_ready", {31'd0, ifc.CFG_READY}, 32'd1);
    $display("seq stop: stopped at cycle %0d", cyc);

    // Reset while a staged config is pending
    en = 1'b1; tick();
    wait_cnt(20);
    drive_cfg(c20, 1'b1);
    tick();
    drive_cfg(c20, 1'b0);
    wait_cnt(55);
    chk("pend_before_reset", {31'd0, ifc.CFG_READY}, 32'd0);
    rst = 1'b1;
    tick();
    chk("reset_outputs", {24'd0, sync, modn, mod, ifc.CFG_ERR}, 32'd0);
    chk("reset_ready", {31'd0, ifc.CFG_READY}, 32'd1);
    rst = 1'b0;
    tick();
    start = cyc;
    repeat (220) tick();
    chk("reset_first_sync", find_sync(start + 1, start + 50), start + 1);
    chk("reset_no_staged", find_sync(start + 2, start + 100), -1);
    chk("reset_default_period", {31'd0, hb(start + 101, 2*NUM_CH)}, 32'd1);
    $display("seq reset-in-pend: restart at %0d", start);

    // Table of boundary configs offered while stopped
    vecs[0]  = '{1,   '{0, 0, 0},     0,   0,   1'b1};
    vecs[1]  = '{0,   '{0, 0, 0},     0,   0,   1'b1};
    vecs[2]  = '{2,   '{0, 1, 1},     1,   0,   1'b0};
    vecs[3]  = '{10,  '{9, 0, 0},     4,   1,   1'b0};
    vecs[4]  = '{10,  '{10, 0, 0},    4,   1,   1'b1};
    vecs[5]  = '{10,  '{0, 0, 12},    4,   1,   1'b1};
    vecs[6]  = '{10,  '{0, 0, 0},     6,   2,   1'b0};
    vecs[7]  = '{10,  '{0, 0, 0},     7,   2,   1'b1};
    vecs[8]  = '{10,  '{0, 3, 9},     0,   5,   1'b0};
    vecs[9]  = '{255, '{254, 0, 100}, 200, 27,  1'b0};
    vecs[10] = '{255, '{0, 0, 0},     255, 1,   1'b1};
    vecs[11] = '{200, '{0, 0, 0},     0,   128, 1'b1};
    vecs[12] = '{30,  '{0, 10, 20},   8,   3,   1'b0};
    rst = 1'b1; en = 1'b0; tick(); rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      drive_cfg(mk_cfg(vecs[k].period, vecs[k].phase[0], vecs[k].phase[1], vecs[k].phase[2],
                       vecs[k].duty, vecs[k].duty, vecs[k].duty, vecs[k].dead), 1'b1);
      tick();
      chk("vec_err", {31'd0, ifc.CFG_ERR}, {31'd0, vecs[k].exp_err});
      chk("vec_ready", {31'd0, ifc.CFG_READY}, 32'd1);
      drive_cfg(drv, 1'b0);
      tick();
      chk("vec_err_clear", {31'd0, ifc.CFG_ERR}, 32'd0);
      $display("vec %0d: period=%0d duty=%0d dead=%0d expect_err=%0d", k, vecs[k].period,
               vecs[k].duty, vecs[k].dead, vecs[k].exp_err);
    end
    en = 1'b1;
    repeat (100) tick();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 199) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) drive_cfg(rand_cfg(), 1'b1);
      else drive_cfg(drv, 1'b0);
      tick();
    end
    $display("random: %0d cycles done", cyc);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mod_clkgen_multi.md
MOD_CLKGEN_MULTI -- requirements
Module: mod_clkgen_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of modulation channels.
REQ-002 SHALL have parameter CNT_W, default 8, width of period/phase/duty/dead-time fields in CLK_IN cycles.
REQ-003 SHALL have parameter RST_PERIOD, default 100, period applied at reset.
REQ-004 SHALL have port CLK_IN  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port RESET  input  1  synchronous reset, active-high.
REQ-006 SHALL have port ENABLE  input  1  run request.
REQ-007 SHALL have port CFG_VALID  input  1  config offered.
REQ-008 SHALL have port CFG_READY  output  1  config accepted when VALID&READY.
REQ-009 SHALL have port CFG_PERIOD  input  CNT_W  period, cycles.
REQ-010 SHALL have port CFG_PHASE  input  NUM_CH*CNT_W  per-channel phase offset, channel i at bits [i*CNT_W +: CNT_W].
REQ-011 SHALL have port CFG_DUTY  input  NUM_CH*CNT_W  per-channel high time of MOD, same packing.
REQ-012 SHALL have port CFG_DEAD  input  CNT_W  non-overlap gap, shared.
REQ-013 SHALL have port CFG_ERR  output  1  one-cycle pulse: offered config rejected.
REQ-014 SHALL have port CLK_OUT_MOD  output  NUM_CH  modulation clocks.
REQ-015 SHALL have port CLK_OUT_MODN  output  NUM_CH  non-overlapping complements.
REQ-016 SHALL have port CLK_OUT_SYNC  output  1  one-cycle pulse at count 0 while running.

Function
REQ-017 SHALL keep a period counter CNT, 0..PERIOD-1, incrementing each cycle in RUN/PEND, wrapping to 0 after PERIOD-1 (wrap = cycle where CNT==PERIOD-1).
REQ-018 SHALL compute per channel P = CNT-PHASE if CNT>=PHASE, else CNT+PERIOD-PHASE (no power-of-two assumption).
REQ-019 SHALL drive MOD[i]=1 iff P<DUTY; MODN[i]=1 iff P>=DUTY+DEAD and P<PERIOD-DEAD; both registered, 1-cycle latency from CNT.
REQ-020 SHALL never assert MOD[i] and MODN[i] in the same cycle.
REQ-021 SHALL use FSM states STOPPED, RUN, PEND.
REQ-022 STOPPED: CNT held 0, all outputs 0; ENABLE=1 -> RUN next cycle with CNT=0.
REQ-023 RUN: accepted config -> PEND; ENABLE=0 -> finish current period, go STOPPED at wrap.
REQ-024 PEND: staged config copied to active set at wrap, then RUN; ENABLE=0 during PEND applies config and goes STOPPED at same wrap.
REQ-025 SHALL assert CFG_READY in STOPPED and RUN, deassert in PEND; in STOPPED accepted config becomes active next cycle.
REQ-026 SHALL reject config (not staged, CFG_ERR pulse, state unchanged) if PERIOD<2, any PHASE>=PERIOD, or any DUTY+2*DEAD>PERIOD.
REQ-027 DUTY=0 SHALL give MOD constantly 0; DEAD=0 SHALL give exact complements.
REQ-028 SHALL pulse CLK_OUT_SYNC aligned (same latency) with CNT==0.
REQ-029 Active config SHALL never change except at wrap or in STOPPED (no glitches/runt pulses).

Reset
REQ-030 RESET SHALL force STOPPED, CNT=0, MOD/MODN/SYNC/CFG_ERR=0, CFG_READY=1 on next edge, overriding any operation.
REQ-031 Active config after reset: PERIOD=RST_PERIOD, all PHASE=0, DUTY=RST_PERIOD/2-1, DEAD=1; staged config discarded.

Structure
REQ-032 Package mod_clkgen_pkg SHALL hold the state enum and default-config constants.
REQ-033 Per-channel compare (REQ-018/019) SHALL be sub-module mod_clkgen_ch, instantiated NUM_CH times.

Verification
REQ-034 Reset, ENABLE=1, defaults: MOD high 49 cycles, MODN high 49, 1-cycle gaps, period 100, SYNC every 100.
REQ-035 PERIOD=10, PHASE={0,3,7}, DUTY=4, DEAD=1: ch1 MOD rises 3 cycles after ch0, ch2 7 cycles after; MODN high P=5..8.
REQ-036 Mid-period config PERIOD=20: CFG_READY low until wrap; old 100-cycle period completes, next SYNC 20 cycles later.
REQ-037 Config PHASE=12 with PERIOD=10: CFG_ERR one pulse, waveform unchanged, READY stays 1.
REQ-038 ENABLE=0 at CNT=40: outputs continue to wrap, then all 0, state STOPPED.
REQ-039 RESET at CNT=55 while PEND: next cycle all outputs 0, CFG_READY=1, defaults active.
